// File: rtl/bus_rr_arbiter_if.sv
// bus_rr_arbiter_if: driver FIFO pop/push bus shared through bus_rr_arbiter
interface bus_rr_arbiter_if #(
  parameter int DRVRS   = 4,
  parameter int PCKG_SZ = 16
);
  logic [DRVRS-1:0]         pndng;
  logic [DRVRS*PCKG_SZ-1:0] D_pop;
  logic [DRVRS-1:0]         pop;
  logic [DRVRS-1:0]         push;
  logic [PCKG_SZ-1:0]       D_push;
  modport master (input pndng, D_pop, output pop, push, D_push);
  modport slave  (output pndng, D_pop, input pop, push, D_push);
endinterface

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin source select, one packet per IDLE/GRANT/DELIVER pass
// Define BUS_ARB_STATS_EN to build the saturating pkt_cnt/drop_cnt counters.
module bus_rr_arbiter #(
  parameter int          DRVRS     = 4,
  parameter int          PCKG_SZ   = 16,
  parameter logic [7:0]  BROADCAST = 8'hFF,
  localparam int         W         = $clog2(DRVRS)
) (
  input  logic             clk,
  input  logic             reset,
  bus_rr_arbiter_if.master bus,
  output logic             busy,
  output logic [W-1:0]     grant_id,
  output logic [15:0]      pkt_cnt,
  output logic [15:0]      drop_cnt
);
  typedef enum logic [1:0] {IDLE, GRANT, DELIVER} state_t;
  state_t             state;
  logic [W-1:0]       ptr;
  logic [W-1:0]       winner;
  logic [W-1:0]       idx;
  logic               found;
  logic [PCKG_SZ-1:0] pkt;
  logic [7:0]         id;
  logic [DRVRS-1:0]   sel;
  logic [DRVRS-1:0]   dmask;
  assign id    = pkt[PCKG_SZ-1 -: 8];
  assign sel   = DRVRS'(1) << grant_id;
  assign dmask = (id == BROADCAST) ? ~sel : (id < 8'(DRVRS)) ? DRVRS'(1) << id : '0;
  // Scan from farthest to nearest so the first pending driver after ptr wins.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = '0;
    for (int k = DRVRS; k >= 1; k--) begin
      idx = W'((int'(ptr) + k) % DRVRS);
      if (bus.pndng[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= W'(DRVRS - 1);
      grant_id <= '0;
      pkt      <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          grant_id <= winner;
          state    <= GRANT;
        end
        GRANT: if (bus.pndng[grant_id]) begin
          pkt   <= bus.D_pop[int'(grant_id)*PCKG_SZ +: PCKG_SZ];
          ptr   <= grant_id;
          state <= DELIVER;
        end else state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // Strobes decode straight from state so an async reset kills them at once.
  assign bus.pop    = (state == GRANT && bus.pndng[grant_id]) ? sel : '0;
  assign bus.push   = (state == DELIVER) ? dmask : '0;
  assign bus.D_push = pkt;
  assign busy       = state != IDLE;
`ifdef BUS_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else if (state == DELIVER) begin
      if (dmask != '0 && pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
      if (dmask == '0 && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign pkt_cnt  = '0;
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: directed scenarios plus randomized traffic against a queue-based FIFO model
module tb_bus_rr_arbiter;
  localparam int N = 4;
  localparam int P = 16;
`ifdef BUS_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic [1:0] grant_id;
  logic [15:0] pkt_cnt, drop_cnt;
  int total = 0;
  int bad = 0;
  logic [15:0] q[N][$];
  int mptr;
  int exp_pkts, exp_drops;
  bus_rr_arbiter_if #(.DRVRS(N), .PCKG_SZ(P)) bus ();
  bus_rr_arbiter #(.DRVRS(N), .PCKG_SZ(P), .BROADCAST(8'hFF)) dut (
    .clk(clk), .reset(rst), .bus(bus), .busy(busy), .grant_id(grant_id),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;

  function automatic logic [3:0] dest(logic [15:0] p, int src);
    if (p[15:8] == 8'hFF) return 4'hF & ~(4'b1 << src);
    if (p[15:8] < N) return 4'b1 << p[15:8];
    return 4'b0;
  endfunction

  function automatic logic [15:0] rand_pkt();
    int r = $urandom_range(0, 5);
    logic [7:0] id = (r < 4) ? 8'(r) : (r == 4) ? 8'hFF : 8'($urandom_range(4, 254));
    return {id, 8'($urandom)};
  endfunction

  function automatic int next_src();
    for (int k = 1; k <= N; k++) if (q[(mptr + k) % N].size() != 0) return (mptr + k) % N;
    return -1;
  endfunction

  task automatic drive_bus();
    for (int i = 0; i < N; i++) begin
      bus.pndng[i] = q[i].size() != 0;
      bus.D_pop[i*P +: P] = (q[i].size() != 0) ? q[i][0] : 16'h0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) q[i].delete();
    drive_bus();
    mptr = N - 1;
    exp_pkts = 0;
    exp_drops = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) q[i].delete();
    drive_bus();
    @(negedge clk);
    total++; if (bus.pop !== 4'b0) begin bad++; $display("FAIL reset_pop got=%b want=0000", bus.pop); end
    total++; if (bus.push !== 4'b0) begin bad++; $display("FAIL reset_push got=%b want=0000", bus.push); end
    total++; if (bus.D_push !== 16'h0) begin bad++; $display("FAIL reset_dpush got=%h want=0000", bus.D_push); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant got=%0d want=0", grant_id); end
    total++; if (pkt_cnt !== 16'h0 || drop_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", pkt_cnt, drop_cnt); end
  endtask

  task automatic test_basic();
    do_reset();
    q[0].push_back(16'h02A5);
    drive_bus();
    @(negedge clk);
    total++; if (bus.pop !== 4'b0) begin bad++; $display("FAIL basic_idle_pop got=%b want=0000", bus.pop); end
    @(negedge clk);
    total++; if (bus.pop !== 4'b0001) begin bad++; $display("FAIL basic_pop got=%b want=0001", bus.pop); end
    total++; if (busy !== 1'b1 || grant_id !== 2'd0) begin bad++; $display("FAIL basic_grant got=%b/%0d want=1/0", busy, grant_id); end
    @(posedge clk); #1 void'(q[0].pop_front()); drive_bus();
    @(negedge clk);
    total++; if (bus.push !== 4'b0100 || bus.pop !== 4'b0) begin bad++; $display("FAIL basic_push got=%b/%b want=0100/0000", bus.push, bus.pop); end
    total++; if (bus.D_push !== 16'h02A5) begin bad++; $display("FAIL basic_dpush got=%h want=02a5", bus.D_push); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || bus.push !== 4'b0) begin bad++; $display("FAIL basic_done got=%b/%b want=0/0000", busy, bus.push); end
    total++; if (pkt_cnt !== (STATS ? 16'd1 : 16'd0)) begin bad++; $display("FAIL basic_pkt_cnt got=%0d want=%0d", pkt_cnt, STATS ? 1 : 0); end
  endtask

  task automatic test_round_robin();
    int t;
    logic [15:0] p;
    do_reset();
    for (int j = 0; j < 3; j++) for (int i = 0; i < N; i++) q[i].push_back({8'($urandom_range(0, 3)), 8'($urandom)});
    drive_bus();
    for (int k = 0; k < 12; k++) begin
      t = 0;
      do @(negedge clk); while (bus.pop == 4'b0 && ++t < 10);
      total++; if (bus.pop !== (4'b1 << (k % N))) begin bad++; $display("FAIL rr_order k=%0d got=%b want=%b", k, bus.pop, 4'b1 << (k % N)); end
      p = q[k % N][0];
      @(posedge clk); #1 void'(q[k % N].pop_front()); drive_bus();
      @(negedge clk);
      total++; if (bus.pop !== 4'b0) begin bad++; $display("FAIL rr_pop_len k=%0d got=%b want=0000", k, bus.pop); end
      total++; if (bus.push !== dest(p, k % N) || bus.D_push !== p) begin bad++; $display("FAIL rr_push k=%0d got=%b/%h want=%b/%h", k, bus.push, bus.D_push, dest(p, k % N), p); end
    end
    @(negedge clk);
    total++; if (pkt_cnt !== (STATS ? 16'd12 : 16'd0)) begin bad++; $display("FAIL rr_pkt_cnt got=%0d want=%0d", pkt_cnt, STATS ? 12 : 0); end
  endtask

  task automatic test_broadcast();
    do_reset();
    q[2].push_back(16'hFF3C);
    drive_bus();
    repeat (2) @(negedge clk);
    total++; if (bus.pop !== 4'b0100) begin bad++; $display("FAIL bc_pop got=%b want=0100", bus.pop); end
    @(posedge clk); #1 void'(q[2].pop_front()); drive_bus();
    @(negedge clk);
    total++; if (bus.push !== 4'b1011 || bus.D_push !== 16'hFF3C) begin bad++; $display("FAIL bc_push got=%b/%h want=1011/ff3c", bus.push, bus.D_push); end
    @(negedge clk);
    total++; if (pkt_cnt !== (STATS ? 16'd1 : 16'd0)) begin bad++; $display("FAIL bc_pkt_cnt got=%0d want=%0d", pkt_cnt, STATS ? 1 : 0); end
  endtask

  task automatic test_drop();
    do_reset();
    q[1].push_back(16'h0711);
    drive_bus();
    repeat (2) @(negedge clk);
    total++; if (bus.pop !== 4'b0010) begin bad++; $display("FAIL drop_pop got=%b want=0010", bus.pop); end
    @(posedge clk); #1 void'(q[1].pop_front()); drive_bus();
    @(negedge clk);
    total++; if (bus.push !== 4'b0 || busy !== 1'b1) begin bad++; $display("FAIL drop_push got=%b/%b want=0000/1", bus.push, busy); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_idle got=%b want=0", busy); end
    total++; if (drop_cnt !== (STATS ? 16'd1 : 16'd0) || pkt_cnt !== 16'd0) begin bad++; $display("FAIL drop_cnt got=%0d/%0d want=%0d/0", drop_cnt, pkt_cnt, STATS ? 1 : 0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    q[1].push_back(16'h0011);
    drive_bus();
    repeat (2) @(negedge clk);
    @(posedge clk); #1 void'(q[1].pop_front()); drive_bus();
    @(negedge clk);
    total++; if (bus.push !== 4'b0001) begin bad++; $display("FAIL rmid_push got=%b want=0001", bus.push); end
    #1 rst = 1'b1;
    #1;
    total++; if (bus.push !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_async got=%b/%b want=0000/0", bus.push, busy); end
    total++; if (bus.D_push !== 16'h0) begin bad++; $display("FAIL rmid_dpush got=%h want=0000", bus.D_push); end
    @(posedge clk); #1 rst = 1'b0;
    q[0].push_back(16'h0155);
    q[3].push_back(16'h0266);
    drive_bus();
    repeat (2) @(negedge clk);
    total++; if (bus.pop !== 4'b0001) begin bad++; $display("FAIL rmid_next got=%b want=0001", bus.pop); end
  endtask

  task automatic test_pndng_drop();
    do_reset();
    q[1].push_back(16'h0000);
    drive_bus();
    repeat (2) @(negedge clk);
    @(posedge clk); #1 void'(q[1].pop_front()); drive_bus();
    @(posedge clk); #1 q[3].push_back(16'h0033); drive_bus();
    @(posedge clk); #1 q[3].delete(); drive_bus();
    @(negedge clk);
    total++; if (bus.pop !== 4'b0 || busy !== 1'b1 || grant_id !== 2'd3) begin bad++; $display("FAIL gdrop_pop got=%b/%b/%0d want=0000/1/3", bus.pop, busy, grant_id); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL gdrop_idle got=%b want=0", busy); end
    q[0].push_back(16'h0101);
    q[2].push_back(16'h0202);
    drive_bus();
    @(negedge clk);
    total++; if (bus.pop !== 4'b0100) begin bad++; $display("FAIL gdrop_ptr_kept got=%b want=0100", bus.pop); end
    @(posedge clk); #1 void'(q[2].pop_front()); drive_bus();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random();
    int added = 0, idle_run = 0, popped, s, cyc = 0;
    bit pend = 0, empty;
    logic [3:0] emask;
    logic [15:0] edata;
    do_reset();
    for (int i = 0; i < 6; i++) begin q[$urandom_range(0, N-1)].push_back(rand_pkt()); added++; end
    drive_bus();
    do begin
      popped = -1;
      @(negedge clk);
      if (pend) begin
        total++; if (bus.push !== emask || bus.D_push !== edata || bus.pop !== 4'b0) begin bad++; $display("FAIL rand_push got=%b/%h/%b want=%b/%h/0000", bus.push, bus.D_push, bus.pop, emask, edata); end
        pend = 0;
      end else if (bus.pop != 4'b0) begin
        s = next_src();
        total++; if (s < 0 || bus.pop !== (4'b1 << s)) begin bad++; $display("FAIL rand_pop got=%b want_src=%0d", bus.pop, s); end
        if (s >= 0) begin
          edata = q[s][0];
          emask = dest(edata, s);
          if (emask != 4'b0) exp_pkts++; else exp_drops++;
          pend = 1; popped = s; mptr = s;
        end
        idle_run = 0;
      end else begin
        total++; if (bus.push !== 4'b0) begin bad++; $display("FAIL rand_push_idle got=%b want=0000", bus.push); end
      end
      empty = 1;
      for (int i = 0; i < N; i++) if (q[i].size() != 0) empty = 0;
      if (!empty && popped < 0 && !pend && ++idle_run > 4) begin
        total++; bad++; $display("FAIL rand_stall got=no_pop want=pop_within_4");
        idle_run = 0;
      end
      @(posedge clk); #1;
      if (popped >= 0) void'(q[popped].pop_front());
      empty = 1;
      for (int i = 0; i < N; i++) if (q[i].size() != 0) empty = 0;
      if (added < 80 && ((popped >= 0 && $urandom_range(0, 1) == 1) || empty)) begin
        q[$urandom_range(0, N-1)].push_back(rand_pkt());
        added++;
      end
      drive_bus();
      empty = 1;
      for (int i = 0; i < N; i++) if (q[i].size() != 0) empty = 0;
    end while (!(added >= 80 && empty && !pend) && ++cyc < 2000);
    repeat (3) @(negedge clk);
    total++; if (pkt_cnt !== (STATS ? 16'(exp_pkts) : 16'd0)) begin bad++; $display("FAIL rand_pkt_cnt got=%0d want=%0d", pkt_cnt, STATS ? exp_pkts : 0); end
    total++; if (drop_cnt !== (STATS ? 16'(exp_drops) : 16'd0)) begin bad++; $display("FAIL rand_drop_cnt got=%0d want=%0d", drop_cnt, STATS ? exp_drops : 0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_broadcast();
    test_drop();
    test_reset_mid();
    test_pndng_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Round-robin bus controller that shares a single packet bus among `DRVRS` driver FIFOs. It pops one packet at a time from a pending source FIFO and pushes it into the destination FIFO or FIFOs named in the packet header. Broadcast packets go to every driver except the source. It sits between the per-driver FIFO `pndng`/`pop`/`D_pop` outputs and the `push`/`D_push` inputs, and is the block that sequences the bus-interface signals.

## Interface
- `DRVRS`, 4: number of drivers/FIFOs; 2..16.
- `PCKG_SZ`, 16: packet width in bits; ≥ 9.
- `BROADCAST`, 8'hFF: header ID value meaning "all drivers".
- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `pndng` input `DRVRS`: bit i set means FIFO i is non-empty and `D_pop` slice i is valid.
- `D_pop` input `DRVRS*PCKG_SZ`: head data of each FIFO; slice i is `[i*PCKG_SZ +: PCKG_SZ]`.
- `pop` output `DRVRS`: one-hot pop strobe to the source FIFO.
- `push` output `DRVRS`: push strobes to destination FIFOs; one-hot, or multi-hot for broadcast.
- `D_push` output `PCKG_SZ`: shared bus data presented to all destination FIFOs.
- `busy` output 1: high in GRANT and DELIVER.
- `grant_id` output `$clog2(DRVRS)`: index of the current or last granted source.
- `pkt_cnt` output 16: packets delivered (see Configuration).
- `drop_cnt` output 16: packets dropped (see Configuration).

## Operation
- The header ID is `pkt[PCKG_SZ-1 -: 8]`. The payload is the remaining bits and is forwarded unchanged.
- States are IDLE, GRANT, DELIVER.
- **IDLE**
  - If any `pndng` bit is set, select the first set bit scanning `ptr+1, ptr+2, …` modulo `DRVRS`.
  - Register the winner into `grant_id`, then go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**
  - `pop[grant_id] = pndng[grant_id]`, combinational and single-cycle.
  - If `pndng[grant_id]` is set, capture `D_pop` slice `grant_id` into `pkt` on this edge, set `ptr <= grant_id`, and go to DELIVER.
  - If `pndng[grant_id]` has dropped, go to IDLE with no pop and `ptr` unchanged.
- **DELIVER**
  - `D_push = pkt`.
  - If ID == `BROADCAST`: `push = ~(1<<grant_id)`.
  - Else if ID < `DRVRS`: `push = 1<<ID`. Self-addressed packets are delivered to the source.
  - Otherwise the packet is dropped: `push = 0`.
  - Always return to IDLE after one cycle.
- `push` and `pop` are never both asserted in the same cycle.
- The round-robin pointer guarantees each pending driver is served within `DRVRS` grants.

## Timing
- Reset values:
  - State IDLE, `pop = 0`, `push = 0`, `D_push = 0`, `busy = 0`, `grant_id = 0`.
  - `ptr = DRVRS-1`, so driver 0 has first priority.
  - Counters are 0.
- Latency: `pndng` sampled high in IDLE at cycle N gives `pop` in cycle N+1 and `push` in cycle N+2.
- Throughput is one packet per 3 cycles; back-to-back packets are possible with no idle gap beyond IDLE.
- `D_push` holds `pkt` through DELIVER and keeps its last value otherwise.
- Reset asserted mid-transfer:
  - `pop` and `push` drop immediately, without waiting for the clock edge.
  - The in-flight packet is lost.
  - The FIFO has already been popped if reset arrives after the GRANT edge.
- Simultaneous `pndng` on all drivers gives grants in order `ptr+1 …` cyclically.

## Configuration
- `BUS_ARB_STATS_EN` defined:
  - `pkt_cnt` increments by 1 per DELIVER with nonzero `push`; a broadcast counts once.
  - `drop_cnt` increments by 1 per dropped packet.
  - Both counters saturate at 16'hFFFF and reset to 0.
- `BUS_ARB_STATS_EN` undefined: counters are not built, and `pkt_cnt`/`drop_cnt` are tied to 0.

## Test plan
- Reset, then `pndng=4'b0001`, `D_pop[0]=16'h0200_|payload 8'hA5` (i.e. 16'h02A5) → `pop=0001` one cycle later, then `push=0100` with `D_push=16'h02A5`, `pkt_cnt=1`.
- All four `pndng` held high with 3 packets each → grant order 0,1,2,3,0,1,2,3,… and each `pop` is exactly one cycle long.
- Driver 2 sends 16'hFF3C → `push=1011`, `D_push=16'hFF3C`, `pkt_cnt` +1.
- Driver 1 sends 16'h0711 with `DRVRS=4` → no `push`, `drop_cnt=1`, back to IDLE.
- Assert `reset` during DELIVER → `push` goes to 0 asynchronously; after release, state IDLE and the next grant goes to driver 0.
- `pndng[3]` deasserted in the GRANT cycle → no `pop`, return to IDLE, and `ptr` keeps its previous value.
